core_if_pf: RTL and testbench

Next-generation instruction fetch stage with a parametrised prefetch queue. It issues pipelined Wishbone reads ahead of decode, up to DEPTH in flight or buffered. It presents a {pc, instr} pair to decode through a valid/halt handshake. On set_pc it flushes the queue and discards stale in-flight responses. It replaces the single-request fetch stage between the instruction bus and decode.

---
 rtl/i2d_core_defines.sv | 12 +
 rtl/wishbone.sv | 14 +
 rtl/core_if_fifo.sv | 51 +++++
 rtl/core_if_pf.sv | 98 +++++++++
 tb/tb_core_if_pf.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2d_core_defines.sv
// Shared core types: instruction word and the {pc, instr} pair handed
// from fetch to decode.
package i2d_core_defines;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        logic [31:0] pc;
        instr_t      instr;
    } fetch_entry_t;

endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bus, reduced to the signals an instruction fetch uses.
interface wishbone;

    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic [31:0] dat_so;

    modport pl_master (output adr, cyc, stb, we, input ack, dat_so);
    modport pl_slave  (input adr, cyc, stb, we, output ack, dat_so);

endinterface

// File: rtl/core_if_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries. The pointers carry an
// extra MSB so that full and empty can be told apart.
module core_if_fifo
    import i2d_core_defines::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: the storage is cleared too, so the head reads as zero
            // straight out of reset rather than as uninitialised data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/core_if_pf.sv
// Instruction fetch stage with prefetch queue: issues pipelined Wishbone
// reads ahead of decode and drops responses made stale by a redirect.
module core_if_pf
    import i2d_core_defines::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    wishbone.pl_master       bus,
    input  logic             if_halt,
    input  logic             set_pc,
    input  logic [31:0]      new_pc,
    output logic [31:0]      if_pc,
    output instr_t           if_instr,
    output logic             if_valid,
    output logic             if_busy
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          empty;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  resp_entry;

    assign target_pc   = {new_pc[31:2], 2'b00};
    assign credit_used = {1'b0, count} + {1'b0, outstanding};

    // A request is only issued while its response is sure to find room.
    assign issue = rst && !set_pc && (credit_used < (CW+1)'(DEPTH));
    assign push  = bus.ack && (discard == '0) && !set_pc;
    assign pop   = if_valid && !if_halt && !set_pc;

    assign resp_entry = '{pc: resp_pc, instr: bus.dat_so};

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(bus.ack);
            if (set_pc) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                // Everything still in flight after this cycle's ack is stale,
                // including responses already marked by an earlier redirect.
                discard  <= outstanding - CW'(bus.ack);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (bus.ack) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
            end
        end
    end

    core_if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (set_pc),
        .push  (push),
        .pop   (pop),
        .din   (resp_entry),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign bus.adr = fetch_pc;
    assign bus.stb = issue;
    assign bus.cyc = issue || (outstanding != '0);
    assign bus.we  = 1'b0;

    assign if_pc    = head.pc;
    assign if_instr = head.instr;
    assign if_valid = !empty;
    assign if_busy  = empty;

endmodule

// File: tb/tb_core_if_pf.sv
// Bench for core_if_pf: a latency-programmable in-order Wishbone slave,
// a decode-side pop monitor, a cycle table and redirect sequences.
module tb_core_if_pf;
    import i2d_core_defines::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_halt = 1'b0;
    logic        set_pc = 1'b0;
    logic [31:0] new_pc = '0;
    logic [31:0] if_pc;
    instr_t      if_instr;
    logic        if_valid;
    logic        if_busy;

    wishbone bus ();

    core_if_pf #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .if_halt  (if_halt),
        .set_pc   (set_pc),
        .new_pc   (new_pc),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_valid (if_valid),
        .if_busy  (if_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Slave: requests seen at a negedge are accepted at the next posedge and
    // acknowledged lat cycles later, in order, one per cycle.
    typedef struct { logic [31:0] adr; int due; } req_t;
    req_t rq[$];
    int   ncyc = 0;
    int   lat = 1;
    int   n_issue = 0;
    int   max_out = 0;

    always @(negedge clk) begin
        if (!rst) begin
            rq.delete();
            bus.ack    <= 1'b0;
            bus.dat_so <= '0;
            n_issue    <= 0;
            max_out    <= 0;
        end else begin
            if (rq.size() > 0 && rq[0].due <= ncyc) begin
                bus.ack    <= 1'b1;
                bus.dat_so <= data_of(rq[0].adr);
                void'(rq.pop_front());
            end else begin
                bus.ack <= 1'b0;
            end
            if (bus.stb) begin
                rq.push_back('{adr: bus.adr, due: ncyc + lat});
                n_issue <= n_issue + 1;
            end
            if (rq.size() > max_out) max_out <= rq.size();
        end
        ncyc <= ncyc + 1;
    end

    // Decode side: record every entry that is popped at the coming edge.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t got[$];

    always @(negedge clk) begin
        if (rst && if_valid && !if_halt && !set_pc) got.push_back('{pc: if_pc, instr: if_instr});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int l);
        rst     = 1'b0;
        if_halt = 1'b0;
        set_pc  = 1'b0;
        new_pc  = '0;
        lat     = l;
        step(2);
        rst = 1'b1;
        got.delete();
    endtask

    task automatic wait_got(input string name, input int n);
        int t = 0;
        while (got.size() < n && t < 100) begin
            step(1);
            t++;
        end
        check(name, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic check_seq(input string name, input int first, input int n, input logic [31:0] pc0);
        int errs = 0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] epc;
            epc = pc0 + 32'(4 * k);
            if (first + k >= got.size()) errs++;
            else if (got[first+k].pc !== epc || got[first+k].instr !== data_of(epc)) errs++;
        end
        check(name, 32'(errs), 32'd0);
    endtask

    typedef struct {
        logic        halt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_stb;
    } vec_t;

    vec_t vt[12];
    int   base;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 32'h000, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 32'h100, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 32'h104, 1'b1};
        vt[3]  = '{1'b1, 1'b1, 32'h104, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 32'h104, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 32'h104, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 32'h108, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 32'h10C, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 32'h110, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 32'h114, 1'b1};
        vt[10] = '{1'b0, 1'b1, 32'h118, 1'b1};
        vt[11] = '{1'b0, 1'b1, 32'h11C, 1'b1};

        // Reset state, held in reset.
        step(1);
        check("rst_stb",   32'(bus.stb), 32'd0);
        check("rst_cyc",   32'(bus.cyc), 32'd0);
        check("rst_we",    32'(bus.we),  32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_busy",  32'(if_busy),  32'd1);
        check("rst_pc",    if_pc,    32'd0);
        check("rst_instr", if_instr, 32'd0);

        // Cycle table: 1-cycle ack, short halt window.
        do_reset(1);
        check("first_adr", bus.adr, 32'h100);
        for (int i = 0; i < 12; i++) begin
            step(1);
            check($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(vt[i].exp_valid));
            check($sformatf("tbl%0d_busy", i),  32'(if_busy),  32'(!vt[i].exp_valid));
            check($sformatf("tbl%0d_pc", i),    if_pc, vt[i].exp_pc);
            check($sformatf("tbl%0d_instr", i), if_instr, vt[i].exp_valid ? data_of(vt[i].exp_pc) : 32'd0);
            check($sformatf("tbl%0d_stb", i),   32'(bus.stb), 32'(vt[i].exp_stb));
            if_halt = vt[i].halt;
        end

        // Halt from reset: the queue fills to DEPTH and fetching stops.
        do_reset(1);
        if_halt = 1'b1;
        step(10);
        check("halt_issued", 32'(n_issue), 32'd4);
        check("halt_stb",    32'(bus.stb), 32'd0);
        check("halt_cyc",    32'(bus.cyc), 32'd0);
        check("halt_head",   if_pc, 32'h100);
        if_halt = 1'b0;
        wait_got("halt_drain", 8);
        check_seq("halt_order", 0, 8, 32'h100);

        // Latency 2: one instruction per cycle once filled.
        do_reset(2);
        step(8);
        base = got.size();
        step(20);
        check("lat2_rate", 32'(got.size() - base), 32'd20);
        check_seq("lat2_order", 0, got.size(), 32'h100);

        // Latency 3: in order, never more than DEPTH in flight.
        do_reset(3);
        step(30);
        check("lat3_maxout", 32'(max_out <= 4), 32'd1);
        check("lat3_some",   32'(got.size() >= 16), 32'd1);
        check_seq("lat3_order", 0, got.size(), 32'h100);

        // Redirect with three requests in flight and no ack that cycle.
        do_reset(4);
        step(3);
        set_pc = 1'b1;
        new_pc = 32'h2003;
        step(1);
        set_pc = 1'b0;
        check("redir_empty", 32'(if_valid), 32'd0);
        wait_got("redir_wait", 4);
        check("redir_first_pc",    got[0].pc,    32'h2000);
        check("redir_first_instr", got[0].instr, data_of(32'h2000));
        check_seq("redir_order", 0, 4, 32'h2000);

        // Redirect in the same cycle as an ack and a pop.
        do_reset(2);
        step(8);
        check("pre_set_valid", 32'(if_valid), 32'd1);
        check("pre_set_ack",   32'(bus.ack),  32'd1);
        base   = got.size();
        set_pc = 1'b1;
        new_pc = 32'h3000;
        step(1);
        set_pc = 1'b0;
        check("set_ack_empty",   32'(if_valid), 32'd0);
        check("set_ack_busy",    32'(if_busy),  32'd1);
        check("set_ack_discard", 32'(dut.discard), 32'd1);
        check("set_ack_nopop",   32'(got.size() - base), 32'd0);
        wait_got("set_ack_wait", base + 3);
        check_seq("set_ack_order", base, 3, 32'h3000);

        // Redirect near the top of the address space wraps to zero.
        do_reset(1);
        set_pc = 1'b1;
        new_pc = 32'hFFFF_FFF8;
        step(1);
        set_pc = 1'b0;
        wait_got("wrap_wait", 4);
        check_seq("wrap_order", 0, 4, 32'hFFFF_FFF8);

        // Back-to-back redirects: the last target wins.
        do_reset(3);
        step(2);
        set_pc = 1'b1;
        new_pc = 32'h5000;
        step(1);
        new_pc = 32'h6004;
        step(1);
        set_pc = 1'b0;
        wait_got("b2b_wait", 3);
        check_seq("b2b_order", 0, 3, 32'h6004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
